// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants and shared coordinate type.
package vga_pkg;
    typedef logic [9:0] coord_t;
    localparam int H_DISPLAY = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int MAX_X     = 640;
    localparam int MAX_Y     = 480;
endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: divides CLK into a one-cycle pixel enable every CLK_DIV cycles.
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_pix_en
);
    import vga_pkg::*;
    // With CLK_DIV=1 the counter is stuck at 0 == LAST, so the enable is constant 1.
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] r_div_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_div_cnt <= '0;
        else          r_div_cnt <= (r_div_cnt == LAST) ? '0 : r_div_cnt + W'(1);
    assign o_pix_en = (r_div_cnt == LAST);
endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster counters, syncs, blanking and strobes.
// Optional frame_cnt port enabled by defining VGA_FRAME_CNT_EN.
module vga_timing #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick,
    output logic       line_tick,
    output logic       frame_tick
`ifdef VGA_FRAME_CNT_EN
    ,output logic [15:0] frame_cnt
`endif
);
    import vga_pkg::*;
    localparam coord_t X_LAST   = coord_t'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t Y_LAST   = coord_t'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FP);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FP);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);
    localparam coord_t X_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t Y_VIS    = coord_t'(V_DISPLAY);

    logic   w_pix_en, w_x_wrap, w_line_wrap, w_frame_wrap;
    coord_t w_x_nxt, w_y_nxt;
    coord_t r_x, r_y;
    logic   r_hsync, r_vsync, r_video_on, r_pix_tick, r_line_tick, r_frame_tick;

    vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (
        .i_clk    (CLK),
        .i_rst_n  (RST_N),
        .o_pix_en (w_pix_en)
    );

    assign w_x_wrap     = (r_x == X_LAST);
    assign w_x_nxt      = !w_pix_en ? r_x : (w_x_wrap ? '0 : r_x + 10'd1);
    assign w_y_nxt      = (w_pix_en && w_x_wrap) ? ((r_y == Y_LAST) ? '0 : r_y + 10'd1) : r_y;
    assign w_line_wrap  = w_pix_en && (w_x_nxt == '0);
    assign w_frame_wrap = w_line_wrap && (w_y_nxt == '0);

    // Syncs and blanking come from the next coordinates so they stay aligned with x/y.
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            r_x          <= X_LAST;
            r_y          <= Y_LAST;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_video_on   <= 1'b0;
            r_pix_tick   <= 1'b0;
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_hsync      <= !(w_x_nxt >= HS_START && w_x_nxt <= HS_END);
            r_vsync      <= !(w_y_nxt >= VS_START && w_y_nxt <= VS_END);
            r_video_on   <= (w_x_nxt < X_VIS) && (w_y_nxt < Y_VIS);
            r_pix_tick   <= w_pix_en;
            r_line_tick  <= w_line_wrap;
            r_frame_tick <= w_frame_wrap;
        end

    assign x          = r_x;
    assign y          = r_y;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    assign pix_tick   = r_pix_tick;
    assign line_tick  = r_line_tick;
    assign frame_tick = r_frame_tick;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N)            r_frame_cnt <= '0;
        else if (w_frame_wrap) r_frame_cnt <= r_frame_cnt + 16'd1;
    assign frame_cnt = r_frame_cnt;
`endif
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: checks three vga_timing instances against a closed-form raster model.
module tb_vga_timing;
    localparam int SH_D = 8, SH_FP = 2, SH_S = 3, SH_BP = 2;
    localparam int SV_D = 5, SV_FP = 2, SV_S = 2, SV_BP = 1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic hs, vs, von, pt, lt, ft;
    } obs_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic [9:0] x0, y0, x1, y1, x2, y2;
    logic hs0, vs0, von0, pt0, lt0, ft0;
    logic hs1, vs1, von1, pt1, lt1, ft1;
    logic hs2, vs2, von2, pt2, lt2, ft2;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc0, fc1, fc2;
`endif

    vga_timing u0 (
        .CLK(CLK), .RST_N(RST_N), .x(x0), .y(y0), .hsync(hs0), .vsync(vs0),
        .video_on(von0), .pix_tick(pt0), .line_tick(lt0), .frame_tick(ft0)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );
    vga_timing #(.CLK_DIV(3), .H_DISPLAY(SH_D), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
                 .V_DISPLAY(SV_D), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)) u1 (
        .CLK(CLK), .RST_N(RST_N), .x(x1), .y(y1), .hsync(hs1), .vsync(vs1),
        .video_on(von1), .pix_tick(pt1), .line_tick(lt1), .frame_tick(ft1)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );
    vga_timing #(.CLK_DIV(1), .H_DISPLAY(SH_D), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
                 .V_DISPLAY(SV_D), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)) u2 (
        .CLK(CLK), .RST_N(RST_N), .x(x2), .y(y2), .hsync(hs2), .vsync(vs2),
        .video_on(von2), .pix_tick(pt2), .line_tick(lt2), .frame_tick(ft2)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc2)
`endif
    );

    int checks = 0, failures = 0;
    int e = 0, tcount = 0;
    logic prev_hs0, hs_arm0, prev_von0, prev_vs1, vs_arm1;
    int hs_low0, vs_low1, last_ft1, last_ft2, lt_cnt1, lt_cnt2, nper1, nper2, hs_falls0;

    // e edges after reset release: a = e/d pixel advances, raster position counts from the last pixel.
    function automatic obs_t model(int ev, int d, int hd, int hfp, int hs, int hbp,
                                   int vd, int vfp, int vs, int vbp);
        obs_t o;
        int ht, vt, n, p, xx, yy;
        ht = hd + hfp + hs + hbp;
        vt = vd + vfp + vs + vbp;
        n  = ht * vt;
        p  = (n - 1 + ev / d) % n;
        xx = p % ht;
        yy = p / ht;
        o.x   = 10'(xx);
        o.y   = 10'(yy);
        o.hs  = !(xx >= hd + hfp && xx < hd + hfp + hs);
        o.vs  = !(yy >= vd + vfp && yy < vd + vfp + vs);
        o.von = (xx < hd) && (yy < vd);
        o.pt  = (ev > 0) && (ev % d == 0);
        o.lt  = o.pt && (xx == 0);
        o.ft  = o.pt && (p == 0);
        return o;
    endfunction

    function automatic logic [15:0] mfc(int ev, int d, int n);
        return 16'((ev / d + n - 1) / n);
    endfunction

    task automatic check_all(input string tag);
        obs_t m, o;
        m = model(e, 2, 640, 16, 96, 48, 480, 10, 2, 33);
        o = '{x0, y0, hs0, vs0, von0, pt0, lt0, ft0};
        checks++;
        assert (o === m) else begin failures++; $error("FAIL %s u0 e=%0d observed=%h expected=%h", tag, e, o, m); end
        m = model(e, 3, SH_D, SH_FP, SH_S, SH_BP, SV_D, SV_FP, SV_S, SV_BP);
        o = '{x1, y1, hs1, vs1, von1, pt1, lt1, ft1};
        checks++;
        assert (o === m) else begin failures++; $error("FAIL %s u1 e=%0d observed=%h expected=%h", tag, e, o, m); end
        m = model(e, 1, SH_D, SH_FP, SH_S, SH_BP, SV_D, SV_FP, SV_S, SV_BP);
        o = '{x2, y2, hs2, vs2, von2, pt2, lt2, ft2};
        checks++;
        assert (o === m) else begin failures++; $error("FAIL %s u2 e=%0d observed=%h expected=%h", tag, e, o, m); end
`ifdef VGA_FRAME_CNT_EN
        checks++;
        assert (fc0 === mfc(e, 2, 420000)) else begin failures++; $error("FAIL %s fc0 observed=%0d expected=%0d", tag, fc0, mfc(e, 2, 420000)); end
        checks++;
        assert (fc1 === mfc(e, 3, 150)) else begin failures++; $error("FAIL %s fc1 observed=%0d expected=%0d", tag, fc1, mfc(e, 3, 150)); end
        checks++;
        assert (fc2 === mfc(e, 1, 150)) else begin failures++; $error("FAIL %s fc2 observed=%0d expected=%0d", tag, fc2, mfc(e, 1, 150)); end
`endif
    endtask

    task automatic clear_mon();
        prev_hs0 = 1'b1; hs_arm0 = 1'b0; prev_von0 = 1'b0;
        prev_vs1 = 1'b1; vs_arm1 = 1'b0;
        last_ft1 = -1; last_ft2 = -1; lt_cnt1 = 0; lt_cnt2 = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        e++;
        tcount++;
        check_all("run");
        if (e == 1) begin
            checks++;
            assert (x0 === 10'd799 && ft0 === 1'b0) else begin failures++; $error("FAIL first_edge x0=%0d ft0=%b expected 799/0", x0, ft0); end
        end
        if (e == 2) begin
            checks++;
            assert (x0 === 10'd0 && y0 === 10'd0 && von0 === 1'b1 && ft0 === 1'b1)
            else begin failures++; $error("FAIL first_advance x=%0d y=%0d von=%b ft=%b expected 0/0/1/1", x0, y0, von0, ft0); end
        end
        if (prev_hs0 && !hs0) begin
            checks++; hs_falls0++;
            assert (x0 === 10'd656) else begin failures++; $error("FAIL hsync_fall x=%0d expected 656", x0); end
            hs_low0 = 0; hs_arm0 = 1'b1;
        end
        if (!hs0) hs_low0++;
        if (!prev_hs0 && hs0 && hs_arm0) begin
            checks++;
            assert (hs_low0 === 192 && x0 === 10'd752) else begin failures++; $error("FAIL hsync_width low=%0d x=%0d expected 192/752", hs_low0, x0); end
            hs_arm0 = 1'b0;
        end
        prev_hs0 = hs0;
        if (prev_von0 && !von0) begin
            checks++;
            assert (x0 === 10'd640) else begin failures++; $error("FAIL video_on_fall x=%0d expected 640", x0); end
        end
        prev_von0 = von0;
        if (prev_vs1 && !vs1) begin
            checks++;
            assert (y1 === 10'd7 && x1 === 10'd0) else begin failures++; $error("FAIL vsync_fall x=%0d y=%0d expected 0/7", x1, y1); end
            vs_low1 = 0; vs_arm1 = 1'b1;
        end
        if (!vs1) vs_low1++;
        if (!prev_vs1 && vs1 && vs_arm1) begin
            checks++;
            assert (vs_low1 === 90) else begin failures++; $error("FAIL vsync_width low=%0d expected 90", vs_low1); end
            vs_arm1 = 1'b0;
        end
        prev_vs1 = vs1;
        if (lt1) lt_cnt1++;
        if (ft1) begin
            if (last_ft1 >= 0) begin
                checks++; nper1++;
                assert (tcount - last_ft1 === 450 && lt_cnt1 === 10)
                else begin failures++; $error("FAIL frame_u1 period=%0d lines=%0d expected 450/10", tcount - last_ft1, lt_cnt1); end
            end
            last_ft1 = tcount; lt_cnt1 = 0;
        end
        if (lt2) lt_cnt2++;
        if (ft2) begin
            if (last_ft2 >= 0) begin
                checks++; nper2++;
                assert (tcount - last_ft2 === 150 && lt_cnt2 === 10)
                else begin failures++; $error("FAIL frame_u2 period=%0d lines=%0d expected 150/10", tcount - last_ft2, lt_cnt2); end
            end
            last_ft2 = tcount; lt_cnt2 = 0;
        end
    endtask

    task automatic do_reset();
        #($urandom_range(1, 3));
        RST_N = 1'b0;
        #1;
        e = 0;
        clear_mon();
        check_all("reset_async");
        repeat (3) begin
            @(posedge CLK);
            #1;
            check_all("reset_hold");
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        hs_falls0 = 0; nper1 = 0; nper2 = 0; hs_low0 = 0; vs_low1 = 0;
        clear_mon();
        RST_N = 1'b0;
        #12;
        check_all("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3300) step();
        checks++;
        assert (hs_falls0 === 2 && nper1 >= 5 && nper2 >= 5)
        else begin failures++; $error("FAIL coverage hs_falls=%0d nper1=%0d nper2=%0d", hs_falls0, nper1, nper2); end
        repeat (8) begin
            repeat ($urandom_range(1, 700)) step();
            do_reset();
        end
        repeat (500) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
